// File: rtl/mcntrl_page_arbiter_pkg.sv
// mcntrl_page_arbiter_pkg: shared FSM states and one-hot helper for the page arbiter
package mcntrl_page_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, ENCODE = 2'd2, WAIT_SEQ = 2'd3} arb_state_t;
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction
endpackage

// File: rtl/mcntrl_page_arbiter_rr_pick.sv
// mcntrl_rr_pick: combinational round-robin picker, first request after index last
//  i_req   requests      i_last  previously served index
//  o_valid any request   o_onehot/o_idx  winner
module mcntrl_rr_pick
  import mcntrl_page_arbiter_pkg::*;
#(
  parameter int NUM_CHN = 4,
  localparam int IW = $clog2(NUM_CHN)
) (
  input  logic [NUM_CHN-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic               o_valid,
  output logic [NUM_CHN-1:0] o_onehot,
  output logic [IW-1:0]      o_idx
);
  int c;
  logic [IW-1:0] w_c;
  always_comb begin
    o_valid = 1'b0;
    o_idx = '0;
    c = 0;
    w_c = '0;
    for (int k = 1; k <= NUM_CHN; k++) begin
      c = (int'(i_last) + k) % NUM_CHN;
      w_c = IW'(c);
      if (!o_valid && i_req[w_c]) begin
        o_valid = 1'b1;
        o_idx = w_c;
      end
    end
  end
  assign o_onehot = o_valid ? NUM_CHN'(onehot16(4'(o_idx))) : '0;
endmodule

// File: rtl/mcntrl_page_arbiter.sv
// mcntrl_page_arbiter: round-robin share of one read/write page encoder pair among NUM_CHN channels
//  clk, rst (async, active-high)
//  i_chn_want/urgent/wr/skip, i_chn_bank/row/col/num128 : per-channel requests and packed page fields
//  o_chn_grant/o_chn_done : one-hot 1-cycle pulses
//  o_bank/row/col/num128/skip : latched page to encoders; o_start_rd/o_start_wr : start pulses
//  i_enc_done_rd/wr, i_seq_done : encoder and sequencer completion; o_busy, o_cur_chn : status
//  MCNTRL_ARB_URGENT_EN : when defined, urgent wanting channels are arbitrated first
module mcntrl_page_arbiter
  import mcntrl_page_arbiter_pkg::*;
#(
  parameter int NUM_CHN = 4,
  parameter int ADDRESS_NUMBER = 15,
  parameter int COLADDR_NUMBER = 10,
  parameter int NUM_XFER_BITS = 6,
  localparam int IW = $clog2(NUM_CHN),
  localparam int CW = COLADDR_NUMBER - 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CHN-1:0]                  i_chn_want,
  input  logic [NUM_CHN-1:0]                  i_chn_urgent,
  input  logic [NUM_CHN-1:0]                  i_chn_wr,
  input  logic [3*NUM_CHN-1:0]                i_chn_bank,
  input  logic [ADDRESS_NUMBER*NUM_CHN-1:0]   i_chn_row,
  input  logic [CW*NUM_CHN-1:0]               i_chn_col,
  input  logic [NUM_XFER_BITS*NUM_CHN-1:0]    i_chn_num128,
  input  logic [NUM_CHN-1:0]                  i_chn_skip,
  output logic [NUM_CHN-1:0]                  o_chn_grant,
  output logic [NUM_CHN-1:0]                  o_chn_done,
  output logic [2:0]                          o_bank,
  output logic [ADDRESS_NUMBER-1:0]           o_row,
  output logic [CW-1:0]                       o_col,
  output logic [NUM_XFER_BITS-1:0]            o_num128,
  output logic                                o_skip,
  output logic                                o_start_rd,
  output logic                                o_start_wr,
  input  logic                                i_enc_done_rd,
  input  logic                                i_enc_done_wr,
  input  logic                                i_seq_done,
  output logic                                o_busy,
  output logic [IW-1:0]                       o_cur_chn
);
  arb_state_t r_state, w_next;
  logic [NUM_CHN-1:0] w_req, w_onehot, r_grant, r_done;
  logic [IW-1:0] w_idx, r_last, r_cur;
  logic w_valid, w_enc_done, w_fin, r_wr, r_sticky, r_busy, r_start_rd, r_start_wr, r_skip;
  logic [2:0] r_bank;
  logic [ADDRESS_NUMBER-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [NUM_XFER_BITS-1:0] r_num128;
`ifdef MCNTRL_ARB_URGENT_EN
  assign w_req = |(i_chn_want & i_chn_urgent) ? (i_chn_want & i_chn_urgent) : i_chn_want;
`else
  logic w_unused;
  assign w_unused = ^i_chn_urgent;
  assign w_req = i_chn_want;
`endif
  mcntrl_rr_pick #(.NUM_CHN(NUM_CHN)) u_pick (
    .i_req(w_req), .i_last(r_last), .o_valid(w_valid), .o_onehot(w_onehot), .o_idx(w_idx)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // only the encoder matching the latched direction can advance the page
  always_comb begin
    w_enc_done = r_wr ? i_enc_done_wr : i_enc_done_rd;
    w_fin = r_sticky | i_seq_done;
    w_next = r_state == IDLE ? (w_valid ? START : IDLE) :
             r_state == START ? ENCODE :
             r_state == ENCODE ? (w_enc_done ? WAIT_SEQ : ENCODE) :
             (w_fin ? IDLE : WAIT_SEQ);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_grant <= '0;
      r_done <= '0;
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      r_busy <= 1'b0;
      r_sticky <= 1'b0;
      r_wr <= 1'b0;
      r_cur <= '0;
      r_last <= IW'(NUM_CHN - 1);
      r_bank <= '0;
      r_row <= '0;
      r_col <= '0;
      r_num128 <= '0;
      r_skip <= 1'b0;
    end else begin
      r_grant <= '0;
      r_done <= '0;
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      if (r_state == IDLE) begin
        r_busy <= w_valid;
        if (w_valid) begin
          r_grant <= w_onehot;
          r_sticky <= 1'b0;
          r_cur <= w_idx;
          r_wr <= i_chn_wr[w_idx];
          r_bank <= i_chn_bank[w_idx*3 +: 3];
          r_row <= i_chn_row[w_idx*ADDRESS_NUMBER +: ADDRESS_NUMBER];
          r_col <= i_chn_col[w_idx*CW +: CW];
          r_num128 <= i_chn_num128[w_idx*NUM_XFER_BITS +: NUM_XFER_BITS];
          r_skip <= i_chn_skip[w_idx];
        end
      end
      if (r_state == START) begin
        r_start_rd <= !r_wr;
        r_start_wr <= r_wr;
      end
      // sequencer may finish before or together with the encoder
      if (r_state == ENCODE && i_seq_done) r_sticky <= 1'b1;
      if (r_state == WAIT_SEQ && w_fin) begin
        r_done <= NUM_CHN'(onehot16(4'(r_cur)));
        r_last <= r_cur;
      end
    end
  assign o_chn_grant = r_grant;
  assign o_chn_done = r_done;
  assign o_bank = r_bank;
  assign o_row = r_row;
  assign o_col = r_col;
  assign o_num128 = r_num128;
  assign o_skip = r_skip;
  assign o_start_rd = r_start_rd;
  assign o_start_wr = r_start_wr;
  assign o_busy = r_busy;
  assign o_cur_chn = r_cur;
endmodule

// File: tb/tb_mcntrl_page_arbiter.sv
// tb_mcntrl_page_arbiter: table-driven and directed checks of the page arbiter
module tb_mcntrl_page_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] want = '0, urgent = '0, wr_v, skip_v;
  logic [11:0] bank_v;
  logic [59:0] row_v;
  logic [27:0] col_v;
  logic [23:0] num_v;
  logic erd = 1'b0, ewr = 1'b0, seq = 1'b0;
  logic [3:0] grant, done;
  logic [2:0] bank;
  logic [14:0] row;
  logic [6:0] col;
  logic [5:0] num128;
  logic skip, srd, swr, busy;
  logic [1:0] cur;
  int checks = 0, failures = 0;
  logic [2:0] e_bank[4];
  logic [14:0] e_row[4];
  logic [6:0] e_col[4];
  logic [5:0] e_num[4];

  always #5 clk = ~clk;

  mcntrl_page_arbiter dut (
    .clk(clk), .rst(rst), .i_chn_want(want), .i_chn_urgent(urgent), .i_chn_wr(wr_v),
    .i_chn_bank(bank_v), .i_chn_row(row_v), .i_chn_col(col_v), .i_chn_num128(num_v),
    .i_chn_skip(skip_v), .o_chn_grant(grant), .o_chn_done(done), .o_bank(bank), .o_row(row),
    .o_col(col), .o_num128(num128), .o_skip(skip), .o_start_rd(srd), .o_start_wr(swr),
    .i_enc_done_rd(erd), .i_enc_done_wr(ewr), .i_seq_done(seq), .o_busy(busy), .o_cur_chn(cur)
  );

  typedef struct packed {
    logic [3:0] want;
    logic erd, ewr, seq;
    logic [3:0] grant, done;
    logic srd, swr, busy;
    logic [1:0] cur;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int ch);
    int n;
    n = 0;
    while (grant == '0 && n < 20) begin step(); n++; end
    chk($sformatf("grant_ch%0d", ch), grant, 64'(1) << ch);
    chk("cur_chn", cur, ch);
    chk("fields", {bank, row, col, num128, skip}, {e_bank[ch], e_row[ch], e_col[ch], e_num[ch], skip_v[ch]});
    chk("busy_at_grant", busy, 1);
    step();
    chk("start", {swr, srd}, wr_v[ch] ? 2'b10 : 2'b01);
    step();
    step();
    if (wr_v[ch]) ewr = 1'b1; else erd = 1'b1;
    step();
    erd = 1'b0;
    ewr = 1'b0;
    seq = 1'b1;
    step();
    seq = 1'b0;
    n = 0;
    while (done == '0 && n < 20) begin step(); n++; end
    chk($sformatf("done_ch%0d", ch), done, 64'(1) << ch);
    chk("busy_at_done", busy, 1);
    if (ch == 2) chk("num_skip_at_done", {num128, skip}, {6'd0, 1'b1});
  endtask

  initial begin
    wr_v = 4'b1010;
    skip_v = 4'b0100;
    e_row = '{15'h1234, 15'h0101, 15'h0102, 15'h7fff};
    e_col = '{7'd5, 7'd6, 7'd7, 7'd127};
    e_num = '{6'd8, 6'd16, 6'd0, 6'd63};
    for (int i = 0; i < 4; i++) begin
      e_bank[i] = 3'(i + 1);
      bank_v[i*3 +: 3] = e_bank[i];
      row_v[i*15 +: 15] = e_row[i];
      col_v[i*7 +: 7] = e_col[i];
      num_v[i*6 +: 6] = e_num[i];
    end
    vt[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0};
    vt[2]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[3]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    vt[6]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1};
    vt[8]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[9]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1};
    vt[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1};
    vt[12] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3};
    vt[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd3};
    vt[14] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3};
    vt[15] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3};
    vt[16] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd3};
    vt[17] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3};
    repeat (2) step();
    chk("reset_outputs", {grant, done, bank, row, col, num128, skip, srd, swr, busy, cur}, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 18; i++) begin
      want = vt[i].want;
      erd = vt[i].erd;
      ewr = vt[i].ewr;
      seq = vt[i].seq;
      step();
      chk($sformatf("vec%0d", i), {grant, done, srd, swr, busy, cur},
          {vt[i].grant, vt[i].done, vt[i].srd, vt[i].swr, vt[i].busy, vt[i].cur});
    end
    {want, erd, ewr, seq} = '0;
    want = 4'b1111;
    for (int k = 0; k < 5; k++) serve(k % 4);
    want = 4'b0000;
    step();
    want = 4'b0001;
    step();
    want = 4'b0000;
    step();
    erd = 1'b1;
    step();
    erd = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_mid_page", {grant, done, bank, row, col, num128, skip, srd, swr, busy, cur}, 0);
    step();
    step();
    rst = 1'b0;
    want = 4'b0110;
    serve(1);
    want = 4'b0000;
    step();
    want = 4'b0001;
    serve(0);
    want = 4'b0000;
    step();
    want = 4'b1110;
    urgent = 4'b1000;
`ifdef MCNTRL_ARB_URGENT_EN
    serve(3);
`else
    serve(1);
`endif
    want = 4'b0000;
    urgent = 4'b0000;
    step();
    step();
    chk("idle_after_urgent", {busy, grant, done}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
